// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) round-robin arbiter in front of a single
// fixed-latency memory. Only one access is in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned LAT = 2,
    parameter int unsigned AW  = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_done,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    localparam logic [2:0] LatM1 = 3'(LAT - 1);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            owner_data_q, owner_data_d;
    logic            last_data_q, last_data_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            sel_ifetch, sel_data;

    // Round-robin: on a tie, the port that did not win last time goes first.
    always_comb begin
        sel_ifetch = 1'b0;
        sel_data   = 1'b0;
        if (i_req && d_req) begin
            sel_ifetch = last_data_q;
            sel_data   = !last_data_q;
        end else begin
            sel_ifetch = i_req;
            sel_data   = d_req;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_data_d = owner_data_q;
        last_data_d  = last_data_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (sel_ifetch) begin
                    owner_data_d = 1'b0;
                    last_data_d  = 1'b0;
                    we_d         = 1'b0;
                    addr_d       = i_addr;
                    state_d      = StIssue;
                end else if (sel_data) begin
                    owner_data_d = 1'b1;
                    last_data_d  = 1'b1;
                    we_d         = d_we;
                    addr_d       = d_addr;
                    if (d_we) begin
                        wdata_d = d_wdata;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = LatM1;
                state_d = (LAT == 1) ? StDone : StWait;
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Last-winner pointer resets to "data" so the first tie goes to fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            owner_data_q <= 1'b0;
            last_data_q  <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_data_q <= owner_data_d;
            last_data_q  <= last_data_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Grants are combinational in IDLE; gate with reset so they drop at once.
    assign i_gnt     = (state_q == StIdle) && sel_ifetch && !reset;
    assign d_gnt     = (state_q == StIdle) && sel_data && !reset;
    assign i_done    = (state_q == StDone) && !owner_data_q;
    assign d_done    = (state_q == StDone) && owner_data_q;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_en    = (state_q == StIssue);
    assign mem_we    = (state_q == StIssue) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table at LAT=2, round-robin,
// reset-abort and a LAT=1 instance.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;

    logic        i_gnt, i_done, d_gnt, d_done, mem_en, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    logic        l1_i_gnt, l1_i_done, l1_d_gnt, l1_d_done, l1_mem_en, l1_mem_we, l1_busy;
    logic [31:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.LAT(2), .AW(32)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.LAT(1), .AW(32)) dut_l1 (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(l1_i_gnt), .i_done(l1_i_done),
        .i_rdata(l1_i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(l1_d_gnt), .d_done(l1_d_done), .d_rdata(l1_d_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(mem_rdata), .busy(l1_busy)
    );

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic        dw;
        logic [31:0] dwd;
        logic [31:0] rd;
        logic [5:0]  ctl;   // {i_gnt, i_done, d_gnt, d_done, mem_en, mem_we}
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic [31:0] da, input logic dw, input logic [31:0] dwd,
                                input logic [31:0] rd, input logic [5:0] ctl,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic bsy);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dw = dw; v.dwd = dwd; v.rd = rd;
        v.ctl = ctl; v.addr = addr; v.wdata = wdata; v.busy = bsy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   found;
        int   cyc;
        int   dcount;

        // c0..c3 fetch wins tie; c4..c7 data load; c8..c11 store;
        // c12..c15 fetch wins tie after store; c16..c19 data load; c20 idle.
        vecs.push_back(mk(1, 0, 1, 'h100, 0, 0, 0,          6'b100000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 'h100, 0, 0, 0,          6'b000010, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 'h100, 0, 0, 0,          6'b000000, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 'h100, 0, 0, 'h11111111, 6'b010000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 'h100, 0, 0, 0,          6'b001000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 'h100, 0, 0, 0,          6'b000010, 'h100, 0, 1));
        vecs.push_back(mk(0, 0, 1, 'h100, 0, 0, 0,          6'b000000, 'h100, 0, 1));
        vecs.push_back(mk(0, 0, 1, 'h100, 0, 0, 'h22222222, 6'b000100, 'h100, 0, 1));
        vecs.push_back(mk(0, 0, 1, 'h20, 1, 'hDEADBEEF, 0,  6'b001000, 'h100, 0, 0));
        vecs.push_back(mk(0, 0, 1, 'h20, 1, 'hDEADBEEF, 0,  6'b000011, 'h20, 'hDEADBEEF, 1));
        vecs.push_back(mk(0, 0, 1, 'h20, 1, 'hDEADBEEF, 0,  6'b000000, 'h20, 'hDEADBEEF, 1));
        vecs.push_back(mk(0, 0, 1, 'h20, 1, 'hDEADBEEF, 'h33333333,
                          6'b000100, 'h20, 'hDEADBEEF, 1));
        vecs.push_back(mk(1, 'h44, 1, 'h30, 0, 0, 0, 6'b100000, 'h20, 'hDEADBEEF, 0));
        vecs.push_back(mk(1, 'h44, 1, 'h30, 0, 0, 0, 6'b000010, 'h44, 'hDEADBEEF, 1));
        vecs.push_back(mk(1, 'h44, 1, 'h30, 0, 0, 0, 6'b000000, 'h44, 'hDEADBEEF, 1));
        vecs.push_back(mk(1, 'h44, 1, 'h30, 0, 0, 'h44444444,
                          6'b010000, 'h44, 'hDEADBEEF, 1));
        vecs.push_back(mk(0, 'h44, 1, 'h30, 0, 0, 0, 6'b001000, 'h44, 'hDEADBEEF, 0));
        vecs.push_back(mk(0, 'h44, 1, 'h30, 0, 0, 0, 6'b000010, 'h30, 'hDEADBEEF, 1));
        vecs.push_back(mk(0, 'h44, 1, 'h30, 0, 0, 0, 6'b000000, 'h30, 'hDEADBEEF, 1));
        vecs.push_back(mk(0, 'h44, 1, 'h30, 0, 0, 'h55555555,
                          6'b000100, 'h30, 'hDEADBEEF, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6'b000000, 'h30, 'hDEADBEEF, 0));

        // Reset state, with a request held high to show grants are masked.
        reset = 1'b1; i_req = 1'b1; i_addr = 0; d_req = 1'b0; d_addr = 0;
        d_we = 1'b0; d_wdata = 0; mem_rdata = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset i_gnt", i_gnt, 0);
        check("reset busy", busy, 0);
        check("reset mem_en", mem_en, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            i_req = v.ir; i_addr = v.ia; d_req = v.dr; d_addr = v.da;
            d_we = v.dw; d_wdata = v.dwd; mem_rdata = v.rd;
            @(negedge clock);
            check($sformatf("row%0d i_gnt", i), i_gnt, v.ctl[5]);
            check($sformatf("row%0d i_done", i), i_done, v.ctl[4]);
            check($sformatf("row%0d d_gnt", i), d_gnt, v.ctl[3]);
            check($sformatf("row%0d d_done", i), d_done, v.ctl[2]);
            check($sformatf("row%0d mem_en", i), mem_en, v.ctl[1]);
            check($sformatf("row%0d mem_we", i), mem_we, v.ctl[0]);
            check($sformatf("row%0d mem_addr", i), mem_addr, v.addr);
            check($sformatf("row%0d mem_wdata", i), mem_wdata, v.wdata);
            check($sformatf("row%0d busy", i), busy, v.busy);
            if (v.ctl[4]) check($sformatf("row%0d i_rdata", i), i_rdata, v.rd);
            if (v.ctl[2]) check($sformatf("row%0d d_rdata", i), d_rdata, v.rd);
            @(posedge clock); #1;
        end

        // Continuous requests: alternate I,D,I,... with LAT+2 spacing.
        i_req = 1'b1; i_addr = 'h80; d_req = 1'b1; d_addr = 'h90; d_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            found = 1'b0;
            cyc = 0;
            while (!found && cyc < 12) begin
                @(negedge clock);
                if (i_gnt || d_gnt) found = 1'b1;
                else cyc++;
            end
            check($sformatf("rr%0d grant seen", k), found, 1);
            check($sformatf("rr%0d gap", k), cyc, (k == 0) ? 0 : 3);
            check($sformatf("rr%0d port", k), {i_gnt, d_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        @(posedge clock); #1;
        i_req = 1'b0; d_req = 1'b0;
        repeat (5) @(posedge clock);
        #1;

        // Reset during WAIT of a data load.
        d_req = 1'b1; d_addr = 'h60; d_we = 1'b0;
        @(negedge clock);
        check("abort d_gnt", d_gnt, 1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("abort busy pre", busy, 1);
        reset = 1'b1; d_req = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort mem_en", mem_en, 0);
        check("abort d_done", d_done, 0);
        check("abort mem_addr", mem_addr, 0);
        check("abort mem_wdata", mem_wdata, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        dcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (d_done) dcount++;
        end
        check("abort no d_done", dcount, 0);
        @(posedge clock); #1;
        i_req = 1'b1; i_addr = 'h70;
        @(negedge clock);
        check("post i_gnt", i_gnt, 1);
        @(posedge clock); #1;
        @(negedge clock);
        check("post mem_en", mem_en, 1);
        check("post mem_addr", mem_addr, 'h70);
        @(posedge clock); #1;
        @(posedge clock); #1;
        mem_rdata = 'h77;
        @(negedge clock);
        check("post i_done", i_done, 1);
        check("post i_rdata", i_rdata, 'h77);
        check("post d_done", d_done, 0);
        @(posedge clock); #1;
        i_req = 1'b0; mem_rdata = 0;

        // LAT=1 instance: ISSUE goes straight to DONE.
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        d_req = 1'b1; d_addr = 'h40; d_we = 1'b0;
        @(negedge clock);
        check("l1 d_gnt", l1_d_gnt, 1);
        @(posedge clock); #1;
        @(negedge clock);
        check("l1 mem_en", l1_mem_en, 1);
        check("l1 mem_addr", l1_mem_addr, 'h40);
        check("l1 d_done early", l1_d_done, 0);
        @(posedge clock); #1;
        mem_rdata = 'hCAFEF00D;
        @(negedge clock);
        check("l1 d_done", l1_d_done, 1);
        check("l1 d_rdata", l1_d_rdata, 'hCAFEF00D);
        check("l1 mem_en off", l1_mem_en, 0);
        @(posedge clock); #1;
        d_req = 1'b0; mem_rdata = 0;
        @(negedge clock);
        check("l1 idle busy", l1_busy, 0);
        check("l1 idle d_done", l1_d_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
